// File: rtl/fetch_unit.sv
// fetch_unit: single-issue PC / instruction-fetch stage with fetch timeout.
// Optional SELF_BRANCH_HALT_EN: a retired branch-to-self halts the unit.
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RESET_PC = 0,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_rvalid,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_done,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              halted,
  output logic              fetch_err,
  output logic [15:0]       retired
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc;
  logic [7:0] cnt;
  logic timeout, self_br;
  assign imem_req = state == FETCH;
  assign instr_valid = state == ISSUE;
  assign halted = state == HALT;
  assign imem_addr = pc;
  assign timeout = !imem_rvalid && cnt == 8'(FETCH_TIMEOUT);
`ifdef SELF_BRANCH_HALT_EN
  assign self_br = branch_taken && branch_target == instr_addr;
`else
  assign self_br = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = FETCH;
      FETCH:   state_n = imem_rvalid ? ISSUE : timeout ? HALT : FETCH;
      ISSUE:   state_n = !instr_done ? ISSUE : self_br ? HALT : FETCH;
      default: state_n = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= ADDR_W'(RESET_PC);
      cnt <= '0;
      instr <= '0;
      instr_addr <= '0;
      fetch_err <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_n;
      if (state == FETCH) begin
        cnt <= imem_rvalid ? '0 : cnt + 8'd1;
        if (imem_rvalid) begin
          instr <= imem_rdata;
          instr_addr <= pc;
        end
        if (timeout) fetch_err <= 1'b1;
      end
      if (state == ISSUE && instr_done) begin
        pc <= branch_taken ? branch_target : pc + ADDR_W'(1);
        retired <= retired + {15'd0, ~&retired};
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized checks of fetch_unit against a transaction-level model.
module tb_fetch_unit;
  logic clk = 0, reset = 1;
  logic imem_req, imem_rvalid = 0, instr_valid, instr_done = 0, branch_taken = 0, halted, fetch_err;
  logic [7:0] imem_addr, instr_addr, branch_target = 0;
  logic [15:0] imem_rdata = 0, instr, retired;
  int n_cmp = 0, n_bad = 0;
  localparam int TO = 15;
  localparam int M_START = 0, M_WAIT = 1, M_HOLD = 2, M_STOP = 3;
`ifdef SELF_BRANCH_HALT_EN
  localparam bit SELF_EN = 1;
`else
  localparam bit SELF_EN = 0;
`endif
  int m_pc, m_mode, m_instr, m_iaddr, m_err, m_ret, m_reqs;

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .instr_valid(instr_valid),
    .instr(instr), .instr_addr(instr_addr), .instr_done(instr_done),
    .branch_taken(branch_taken), .branch_target(branch_target), .halted(halted),
    .fetch_err(fetch_err), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, int a, int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Model: what each cycle's sampled inputs imply, in terms of fetch/hold/stop phases.
  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0; m_mode = M_START; m_instr = 0; m_iaddr = 0; m_err = 0; m_ret = 0; m_reqs = 0;
    end else if (m_mode == M_START) begin
      m_mode = M_WAIT; m_reqs = 0;
    end else if (m_mode == M_WAIT) begin
      m_reqs++;
      if (imem_rvalid) begin
        m_instr = imem_rdata; m_iaddr = m_pc; m_mode = M_HOLD;
      end else if (m_reqs > TO) begin
        m_err = 1; m_mode = M_STOP;
      end
    end else if (m_mode == M_HOLD && instr_done) begin
      if (m_ret < 65535) m_ret++;
      m_mode = (SELF_EN && branch_taken && branch_target == m_iaddr) ? M_STOP : M_WAIT;
      m_pc = branch_taken ? int'(branch_target) : (m_pc + 1) % 256;
      m_reqs = 0;
    end
    #1;
    chk("imem_req", imem_req, m_mode == M_WAIT);
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, m_mode == M_HOLD);
    chk("halted", halted, m_mode == M_STOP);
    chk("fetch_err", fetch_err, m_err);
    chk("retired", retired, m_ret);
    if (m_mode == M_HOLD) begin
      chk("instr", instr, m_instr);
      chk("instr_addr", instr_addr, m_iaddr);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; cyc(); reset = 0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin cyc(); n++; end
    chk("req_seen", imem_req, 1);
  endtask

  task automatic fetch_check(int addr, int lat, logic [15:0] d);
    wait_req();
    chk("fetch_addr", imem_addr, addr);
    repeat (lat) cyc();
    imem_rvalid = 1; imem_rdata = d; cyc(); imem_rvalid = 0;
  endtask

  task automatic retire(logic bt, logic [7:0] tgt);
    instr_done = 1; branch_taken = bt; branch_target = tgt; cyc();
    instr_done = 0; branch_taken = 0;
  endtask

  initial begin
    int n;
    cyc();
    do_reset();
    chk("rst_valid", instr_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_ret", retired, 0);
    chk("rst_err", fetch_err, 0);
    // basic fetch with 2-cycle memory latency
    fetch_check(0, 2, 16'h1234);
    chk("t1_valid", instr_valid, 1);
    chk("t1_instr", instr, 16'h1234);
    chk("t1_iaddr", instr_addr, 0);
    retire(0, 0);
    chk("t1_req", imem_req, 1);
    chk("t1_next", imem_addr, 1);
    chk("t1_ret", retired, 1);
    // sequential wrap from FE
    fetch_check(1, 0, 16'h0001);
    retire(1, 8'hFE);
    fetch_check(8'hFE, 1, 16'h00FE); retire(0, 0);
    fetch_check(8'hFF, 0, 16'h00FF); retire(0, 0);
    fetch_check(8'h00, 3, 16'h0100); retire(1, 8'h05);
    // taken branch, and branch pulses without instr_done
    fetch_check(5, 1, 16'hBEEF);
    chk("t3_iaddr", instr_addr, 5);
    branch_taken = 1; branch_target = 8'h44; cyc(); branch_taken = 0;
    chk("t3_hold", instr_valid, 1);
    chk("t3_pc", imem_addr, 5);
    retire(1, 8'h20);
    chk("t3_target", imem_addr, 8'h20);
    retire(1, 8'h77);
    chk("t3_ignored", imem_addr, 8'h20);
    // timeout
    do_reset();
    wait_req();
    n = 0;
    while (imem_req && n < 40) begin cyc(); n++; end
    chk("t4_reqs", n, 16);
    chk("t4_err", fetch_err, 1);
    chk("t4_halt", halted, 1);
    imem_rvalid = 1; retire(0, 0); imem_rvalid = 0;
    chk("t4_stay", halted, 1);
    do_reset();
    chk("t4_clr_err", fetch_err, 0);
    chk("t4_clr_halt", halted, 0);
    wait_req();
    chk("t4_addr", imem_addr, 0);
    // reset mid-FETCH with a late rvalid
    reset = 1; imem_rvalid = 1; cyc(); reset = 0;
    chk("t5_req", imem_req, 0);
    chk("t5_valid", instr_valid, 0);
    cyc(); imem_rvalid = 0;
    chk("t5_late", instr_valid, 0);
    chk("t5_refetch", imem_req, 1);
    // reset mid-ISSUE
    fetch_check(0, 1, 16'hAAAA); retire(0, 0);
    fetch_check(1, 0, 16'hBBBB);
    chk("t5_issue", instr_valid, 1);
    do_reset();
    chk("t5_ret", retired, 0);
    chk("t5_pc", imem_addr, 0);
    chk("t5_v", instr_valid, 0);
    // branch-to-self
    fetch_check(0, 0, 16'h0007); retire(1, 8'h07);
    fetch_check(7, 0, 16'h7777); retire(1, 8'h07);
`ifdef SELF_BRANCH_HALT_EN
    chk("t6_halt", halted, 1);
    n = 0;
    repeat (6) begin n += imem_req; cyc(); end
    chk("t6_noreq", n, 0);
    chk("t6_ret", retired, 2);
`else
    chk("t6_req", imem_req, 1);
    chk("t6_addr", imem_addr, 7);
    fetch_check(7, 1, 16'h7777); retire(1, 8'h07);
    chk("t6_again", imem_addr, 7);
`endif
    // randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      imem_rvalid = $urandom_range(0, 2) == 0;
      imem_rdata = 16'($urandom);
      instr_done = $urandom_range(0, 2) == 0;
      branch_taken = $urandom_range(0, 1) == 1;
      branch_target = $urandom_range(0, 3) == 0 ? instr_addr : 8'($urandom);
      reset = (halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0;
      cyc();
    end
    imem_rvalid = 0; instr_done = 0; branch_taken = 0; reset = 0;
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
